imem_arb: RTL and testbench
===========================

# imem_arb

Arbiter and sequencer for the single-port instruction memory. It owns the memory port and shares it between three requesters: the fetch stage (reads), a program loader (streamed writes at boot or reload) and a debug port (reads). After reset it holds fetch off until the program image is loaded. It then serves fetch with priority, and grants debug through a starvation guard. It drives the fetch-stage stall that freezes the PC.

## Interface
- AW, 10, word-address width (memory depth 2^AW words)
- STARVE_MAX, 4, debug wait cycles before a forced debug grant (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request
- f_addr  in  32  fetch byte address; word index f_addr[AW+1:2]
- f_gnt  out  1  fetch granted this cycle
- f_valid  out  1  f_rdata valid (one cycle after f_gnt)
- f_rdata  out  32  fetch instruction word
- fetch_stall  out  1  f_req & ~f_gnt, drives the fetch PC hold
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader word
- ld_last  in  1  marks the final loader word
- ld_ready  out  1  loader word accepted when ld_valid & ld_ready
- dbg_req  in  1  debug read request
- dbg_addr  in  AW  debug word address
- dbg_gnt  out  1  debug granted this cycle
- dbg_valid  out  1  dbg_rdata valid (one cycle after dbg_gnt)
- dbg_rdata  out  32  debug read word
- reload  in  1  single-cycle pulse: re-enter load mode
- boot_done  out  1  high in RUN
- mem_en, mem_we  out  1 each  memory enable and write enable
- mem_addr  out  AW  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, registered, one-cycle latency

## Operation
- States: LOAD, RUN, DRAIN.
- Reset state is LOAD with wptr=0, starve=0 and all outputs 0, except fetch_stall, which follows f_req.
- **LOAD**
  - ld_ready=1. Each accepted word is written at wptr, then wptr increments.
  - Go to RUN on an accepted ld_last, or on the accept at wptr=2^AW-1. wptr wraps to 0.
  - f_gnt=0 and dbg_gnt=0.
- **RUN**
  - ld_ready=0; ld_valid is ignored.
  - Grant priority: forced debug (starve==STARVE_MAX and dbg_req) wins, then fetch, then debug.
  - Exactly one grant per cycle at most. The granted requester's address drives mem_addr with mem_en=1 and mem_we=0.
  - starve increments on each cycle with dbg_req & ~dbg_gnt, saturating at STARVE_MAX. It clears on dbg_gnt or when dbg_req is low.
- **reload**
  - In RUN, go to DRAIN. DRAIN issues no grants and returns the outstanding read's valid, then moves to LOAD with wptr=0 the next cycle.
  - reload in LOAD or DRAIN is ignored.
- f_valid and dbg_valid are registered copies of the previous cycle's f_gnt and dbg_gnt. Their rdata is mem_rdata.
- Reset mid-operation aborts everything immediately: outputs as at reset, and memory contents are untouched.

## Timing
- Read latency: grant at cycle N, valid and data at cycle N+1.
- Back-to-back fetch grants run at one word per cycle.
- Load throughput: one word per cycle. The write lands on the accepting edge.
- LOAD→RUN: the first grant is possible in the cycle after the final accept.
- Simultaneous reload and grant in RUN: the grant is honoured, and that read completes during DRAIN.
- A forced debug grant costs fetch exactly one stall cycle, after which starve=0.
- fetch_stall is combinational and has no added latency.

## Structure
- Package imem_pkg holds:
  - the state enum (LOAD, RUN, DRAIN);
  - default AW and STARVE_MAX constants;
  - the grant-source enum (NONE, FETCH, DEBUG), used for the valid pipeline.
- Sub-module imem_starve_cnt holds the saturating starvation counter and the force flag.
- The memory array itself is external.

## Test plan
- **Boot load.** Reset, then stream 3 words 0x3C010001, 0x3C020002, 0x00221820 with ld_last on the third. Required: mem writes to addresses 0,1,2; boot_done rises the next cycle; f_req at address 0x4 returns 0x3C020002 one cycle after f_gnt.
- **Full-depth wrap.** With AW=3, stream 8 words with no ld_last. Required: RUN entered after the 8th accept, and wptr=0.
- **Starvation.** Hold f_req and dbg_req continuously. Required: dbg_gnt every 5th cycle (STARVE_MAX=4), and fetch_stall high exactly on those cycles.
- **Reload with outstanding read.** Assert reload in the cycle f_gnt is high. Required: f_valid next cycle in DRAIN, then LOAD, with ld_ready=1 and wptr=0.
- **Async reset mid-load.** Drop rst after 2 loader words, asynchronously to clk. Required: all outputs clear immediately, and a fresh load restarts at address 0.
- **Fetch during LOAD.** Hold f_req=1. Required: f_gnt=0 and fetch_stall=1 until RUN.

Source files
------------

// File: rtl/imem_pkg.sv
// Purpose: shared types and defaults for the instruction-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

    localparam int DEF_AW         = 10;
    localparam int DEF_STARVE_MAX = 4;
    localparam int STARVE_W       = 4;   // holds STARVE_MAX up to 15

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Which requester owns the read returning next cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FETCH,
        SRC_DEBUG
    } src_t;

endpackage

// File: rtl/imem_arb_if.sv
// Purpose: single-port instruction memory bus (master = arbiter, slave = memory).
// Latency: mem_rdata returns one cycle after a read enable.
// Backpressure: none; the memory accepts one access every cycle.
// Ports: mem_en, mem_we, mem_addr[AW], mem_wdata[32] from master; mem_rdata[32] from slave.
interface imem_arb_if import imem_pkg::*; #(
    parameter int AW = DEF_AW
) ();
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/imem_starve_cnt.sv
// Purpose: saturating debug starvation counter; raises force_gnt when debug has waited STARVE_MAX cycles.
// Latency: force_gnt is combinational from the registered count and dbg_req.
// Backpressure: none. Ports: clk, rst, run, dbg_req, dbg_gnt in; force_gnt out.
module imem_starve_cnt import imem_pkg::*; #(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_gnt
);

    localparam logic [STARVE_W-1:0] MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve;

    // Only waiting cycles in RUN count; any grant or a dropped request restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (!run || !dbg_req || dbg_gnt) begin
            starve <= '0;
        end else if (starve != MAX) begin
            starve <= starve + 1'b1;
        end
    end

    assign force_gnt = run && dbg_req && (starve == MAX);

endmodule

// File: rtl/imem_arb.sv
// Purpose: owns the instruction memory port; boot/reload loader writes, then fetch-priority reads with starvation-guarded debug.
// Latency: grant and address in the same cycle, f_valid/dbg_valid and rdata one cycle later; loader writes land on the accepting edge.
// Backpressure: fetch_stall = f_req & ~f_gnt; ld_ready high only in LOAD; debug waits until granted.
// Ports: clk, rst; fetch f_*; loader ld_*; debug dbg_*; reload, boot_done; mem (imem_arb_if master).
module imem_arb import imem_pkg::*; #(
    parameter int AW         = DEF_AW,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [31:0]   f_rdata,
    output logic          fetch_stall,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_gnt,
    output logic          dbg_valid,
    output logic [31:0]   dbg_rdata,
    input  logic          reload,
    output logic          boot_done,
    imem_arb_if.master    mem
);

    state_t        state;
    logic [AW-1:0] wptr;
    src_t          src_q;
    logic          run;
    logic          ld_acc;
    logic          ld_end;
    logic          force_gnt;
    logic [AW-1:0] f_word;
    logic          unused_addr;

    assign run    = (state == ST_RUN);
    assign f_word = f_addr[AW+1:2];
    assign unused_addr = ^{f_addr[31:AW+2], f_addr[1:0]};

    // ld_ready is itself only high in LOAD, so ld_acc needs no state term.
    assign ld_acc = ld_valid & ld_ready;
    assign ld_end = ld_acc & (ld_last | (wptr == {AW{1'b1}}));

    // ld_ready and boot_done are registered copies of the next state, so both
    // read 0 while reset is asserted and during the first cycle after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            wptr      <= '0;
            ld_ready  <= 1'b0;
            boot_done <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    ld_ready <= 1'b1;
                    if (ld_acc) begin
                        wptr <= wptr + 1'b1;
                    end
                    if (ld_end) begin
                        state     <= ST_RUN;
                        ld_ready  <= 1'b0;
                        boot_done <= 1'b1;
                        wptr      <= '0;   // full-depth load wraps here anyway
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        state     <= ST_DRAIN;
                        boot_done <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state    <= ST_LOAD;
                    ld_ready <= 1'b1;
                    wptr     <= '0;
                end
                default: begin
                    state     <= ST_LOAD;
                    ld_ready  <= 1'b0;
                    boot_done <= 1'b0;
                    wptr      <= '0;
                end
            endcase
        end
    end

    imem_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .dbg_req   (dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_gnt (force_gnt)
    );

    // A forced debug grant pre-empts fetch; otherwise debug only gets idle slots.
    assign f_gnt       = run & f_req & ~force_gnt;
    assign dbg_gnt     = run & dbg_req & (force_gnt | ~f_req);
    assign fetch_stall = f_req & ~f_gnt;

    always_comb begin
        mem.mem_en    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (ld_acc) begin
            mem.mem_en    = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = wptr;
            mem.mem_wdata = ld_data;
        end else if (f_gnt) begin
            mem.mem_en   = 1'b1;
            mem.mem_addr = f_word;
        end else if (dbg_gnt) begin
            mem.mem_en   = 1'b1;
            mem.mem_addr = dbg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= SRC_NONE;
        end else if (f_gnt) begin
            src_q <= SRC_FETCH;
        end else if (dbg_gnt) begin
            src_q <= SRC_DEBUG;
        end else begin
            src_q <= SRC_NONE;
        end
    end

    assign f_valid   = (src_q == SRC_FETCH);
    assign dbg_valid = (src_q == SRC_DEBUG);
    assign f_rdata   = f_valid   ? mem.mem_rdata : '0;
    assign dbg_rdata = dbg_valid ? mem.mem_rdata : '0;

endmodule

// File: tb/tb_imem_arb.sv
// Purpose: directed scoreboard bench for imem_arb (AW=10 main instance, AW=3 wrap instance).
// Latency: expected read data queued at grant, popped by the monitor on valid.
// Backpressure: stimulus is cycle-stepped; a watchdog bounds the run.
module tb_imem_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        f_req = 0, f_gnt, f_valid, fetch_stall;
    logic [31:0] f_addr = 0, f_rdata;
    logic        ld_valid = 0, ld_last = 0, ld_ready;
    logic [31:0] ld_data = 0;
    logic        dbg_req = 0, dbg_gnt, dbg_valid;
    logic [9:0]  dbg_addr = 0;
    logic [31:0] dbg_rdata;
    logic        reload = 0, boot_done;

    logic        s_f_req = 0, s_f_gnt, s_f_valid, s_fetch_stall;
    logic [31:0] s_f_addr = 0, s_f_rdata;
    logic        s_ld_valid = 0, s_ld_last = 0, s_ld_ready;
    logic [31:0] s_ld_data = 0;
    logic        s_dbg_gnt, s_dbg_valid;
    logic [2:0]  s_dbg_addr = 0;
    logic [31:0] s_dbg_rdata;
    logic        s_boot_done;

    imem_arb_if #(.AW(10)) mif ();
    imem_arb_if #(.AW(3))  sif ();

    imem_arb #(.AW(10), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
        .f_rdata(f_rdata), .fetch_stall(fetch_stall),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_valid(dbg_valid),
        .dbg_rdata(dbg_rdata), .reload(reload), .boot_done(boot_done), .mem(mif)
    );

    imem_arb #(.AW(3), .STARVE_MAX(4)) u_small (
        .clk(clk), .rst(rst),
        .f_req(s_f_req), .f_addr(s_f_addr), .f_gnt(s_f_gnt), .f_valid(s_f_valid),
        .f_rdata(s_f_rdata), .fetch_stall(s_fetch_stall),
        .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
        .dbg_req(1'b0), .dbg_addr(s_dbg_addr), .dbg_gnt(s_dbg_gnt), .dbg_valid(s_dbg_valid),
        .dbg_rdata(s_dbg_rdata), .reload(1'b0), .boot_done(s_boot_done), .mem(sif)
    );

    // Registered single-port memories, one-cycle read latency.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_s [0:7];
    always @(posedge clk) begin
        if (mif.mem_en) begin
            if (mif.mem_we) mem_a[mif.mem_addr] <= mif.mem_wdata;
            else            mif.mem_rdata <= mem_a[mif.mem_addr];
        end
        if (sif.mem_en) begin
            if (sif.mem_we) mem_s[sif.mem_addr] <= sif.mem_wdata;
            else            sif.mem_rdata <= mem_s[sif.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] fq[$];
    logic [31:0] dq[$];
    logic [31:0] sq[$];
    logic [31:0] boot [0:2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (f_valid) begin
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL f_valid_unexpected: got data %h, expected no valid", f_rdata);
            end else check("f_rdata", f_rdata, fq.pop_front());
        end
        if (dbg_valid) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL dbg_valid_unexpected: got data %h, expected no valid", dbg_rdata);
            end else check("dbg_rdata", dbg_rdata, dq.pop_front());
        end
        if (s_f_valid) begin
            if (sq.size() == 0) begin
                checks++; errors++;
                $display("FAIL s_f_valid_unexpected: got data %h, expected no valid", s_f_rdata);
            end else check("s_f_rdata", s_f_rdata, sq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish within budget");
        $fatal(1);
    end

    initial begin
        boot[0] = 32'h3C010001;
        boot[1] = 32'h3C020002;
        boot[2] = 32'h00221820;

        // Reset state, with fetch already requesting.
        f_req  = 1'b1;
        f_addr = 32'h4;
        #12;
        check("rst_fetch_stall", 32'(fetch_stall), 1);
        check("rst_f_gnt",       32'(f_gnt), 0);
        check("rst_ld_ready",    32'(ld_ready), 0);
        check("rst_boot_done",   32'(boot_done), 0);
        check("rst_mem_en",      32'(mif.mem_en), 0);
        @(negedge clk);
        rst = 1'b1;
        tick;

        // Boot load with fetch held off.
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = boot[i];
            ld_last  = (i == 2);
            @(negedge clk);
            check("load_ready",   32'(ld_ready), 1);
            check("load_we",      32'(mif.mem_we), 1);
            check("load_addr",    32'(mif.mem_addr), 32'(i));
            check("load_wdata",   mif.mem_wdata, boot[i]);
            check("load_f_gnt",   32'(f_gnt), 0);
            check("load_stall",   32'(fetch_stall), 1);
            check("load_bootdn",  32'(boot_done), 0);
            tick;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        check("run_boot_done", 32'(boot_done), 1);
        check("run_ld_ready",  32'(ld_ready), 0);
        check("run_f_gnt",     32'(f_gnt), 1);
        check("run_f_addr",    32'(mif.mem_addr), 1);
        check("run_stall",     32'(fetch_stall), 0);
        fq.push_back(boot[1]);
        tick;

        // Back-to-back fetches.
        for (int i = 0; i < 3; i++) begin
            f_addr = 32'(i * 4);
            @(negedge clk);
            check("b2b_f_gnt", 32'(f_gnt), 1);
            check("b2b_addr",  32'(mif.mem_addr), 32'(i));
            fq.push_back(boot[i]);
            tick;
        end
        f_req = 1'b0;

        // Debug alone is granted immediately.
        dbg_req  = 1'b1;
        dbg_addr = 10'd2;
        @(negedge clk);
        check("dbg_only_gnt", 32'(dbg_gnt), 1);
        check("dbg_only_addr", 32'(mif.mem_addr), 2);
        dq.push_back(boot[2]);
        tick;
        dbg_req = 1'b0;
        tick;

        // Starvation: debug forced every 5th cycle.
        f_req    = 1'b1;
        f_addr   = 32'h0;
        dbg_req  = 1'b1;
        dbg_addr = 10'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_dbg_gnt", 32'(dbg_gnt), 32'((i % 5) == 4));
            check("starve_f_gnt",   32'(f_gnt),   32'((i % 5) != 4));
            check("starve_stall",   32'(fetch_stall), 32'((i % 5) == 4));
            if ((i % 5) == 4) dq.push_back(boot[1]);
            else              fq.push_back(boot[0]);
            tick;
        end
        dbg_req = 1'b0;

        // Reload in the same cycle as a fetch grant.
        f_addr = 32'h8;
        reload = 1'b1;
        @(negedge clk);
        check("reload_f_gnt", 32'(f_gnt), 1);
        fq.push_back(boot[2]);
        tick;
        reload = 1'b0;
        @(negedge clk);
        check("drain_f_gnt",    32'(f_gnt), 0);
        check("drain_f_valid",  32'(f_valid), 1);
        check("drain_stall",    32'(fetch_stall), 1);
        check("drain_ld_ready", 32'(ld_ready), 0);
        check("drain_boot",     32'(boot_done), 0);
        tick;
        f_req = 1'b0;
        @(negedge clk);
        check("reld_ld_ready", 32'(ld_ready), 1);
        check("reld_mem_en",   32'(mif.mem_en), 0);
        tick;

        // Two words of a reload, then async reset mid-load.
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h11111111 * (i + 1);
            @(negedge clk);
            check("reld_addr", 32'(mif.mem_addr), 32'(i));
            tick;
        end
        ld_data = 32'h33333333;
        f_req   = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_en",    32'(mif.mem_en), 0);
        check("arst_mem_we",    32'(mif.mem_we), 0);
        check("arst_mem_wdata", mif.mem_wdata, 0);
        check("arst_ld_ready",  32'(ld_ready), 0);
        check("arst_boot_done", 32'(boot_done), 0);
        check("arst_f_gnt",     32'(f_gnt), 0);
        check("arst_f_valid",   32'(f_valid), 0);
        check("arst_stall",     32'(fetch_stall), 1);
        ld_valid = 1'b0;
        f_req    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick;

        // Fresh load restarts at address 0; word 2 is untouched.
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hAAAA0000 + 32'(i);
            ld_last  = (i == 1);
            @(negedge clk);
            check("fresh_addr", 32'(mif.mem_addr), 32'(i));
            check("fresh_we",   32'(mif.mem_we), 1);
            tick;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        f_req    = 1'b1;
        f_addr   = 32'h4;
        @(negedge clk);
        check("fresh_f_gnt", 32'(f_gnt), 1);
        fq.push_back(32'hAAAA0001);
        tick;
        f_addr = 32'h8;
        @(negedge clk);
        check("fresh_f_gnt2", 32'(f_gnt), 1);
        fq.push_back(boot[2]);
        tick;
        f_req = 1'b0;
        tick;

        // Full-depth wrap on the AW=3 instance.
        for (int i = 0; i < 8; i++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 32'h50000000 + 32'(i);
            @(negedge clk);
            check("wrap_addr",  32'(sif.mem_addr), 32'(i));
            check("wrap_ready", 32'(s_ld_ready), 1);
            check("wrap_boot",  32'(s_boot_done), 0);
            tick;
        end
        s_ld_valid = 1'b0;
        s_f_req    = 1'b1;
        s_f_addr   = 32'h1C;
        @(negedge clk);
        check("wrap_boot_done", 32'(s_boot_done), 1);
        check("wrap_ld_ready",  32'(s_ld_ready), 0);
        check("wrap_wptr",      32'(u_small.wptr), 0);
        check("wrap_f_gnt",     32'(s_f_gnt), 1);
        check("wrap_f_addr",    32'(sif.mem_addr), 7);
        sq.push_back(32'h50000007);
        tick;
        s_f_req = 1'b0;
        tick;
        tick;

        check("fq_drained", 32'(fq.size()), 0);
        check("dq_drained", 32'(dq.size()), 0);
        check("sq_drained", 32'(sq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
